// File: rtl/out_fifo_array.sv
// out_fifo_array
//   Output-side re-alignment buffer behind the MAC row array. Each column has
//   its own FIFO fed by that column's valid strobe. Columns arrive on a skewed
//   schedule. Once every column holds an entry, one aligned row is popped per
//   read.
//
//   Optional feature: define OUT_FIFO_OVERFLOW_FLAG_EN to add the sticky
//   o_overflow output, which records dropped pushes.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in         psum bus; column i is in[psum_bw*(i+1)-1 : psum_bw*i]
//   wr         per-column push strobe
//   rd         pop one aligned row from all columns
//   o_valid    every column holds at least one entry
//   o_full     at least one column holds depth entries
//   o_ready    ~o_full
//   out        registered popped row, same packing as in
//   out_valid  one-cycle pulse when out carries a freshly popped row
//   o_overflow sticky drop flag (OUT_FIFO_OVERFLOW_FLAG_EN builds only)
module out_fifo_array #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_valid
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
    ,
    output logic                   o_overflow
`endif
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    // Storage is deliberately left out of reset.
    logic [psum_bw-1:0] mem_q [col][depth];

    logic [col-1:0][AW-1:0] wrptr_q, wrptr_d;
    logic [col-1:0][CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]          rdptr_q, rdptr_d;
    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [col-1:0]         push;
    logic [col-1:0]         drop;
    logic                   rd_acc;

    // Status flags come straight from the registered counts.
    always_comb begin
        o_valid = 1'b1;
        o_full  = 1'b0;
        for (int i = 0; i < col; i++) begin
            if (cnt_q[i] == '0)      o_valid = 1'b0;
            if (cnt_q[i] == FULL_CNT) o_full = 1'b1;
        end
        o_ready = ~o_full;
    end

    always_comb begin
        rd_acc      = rd && o_valid;
        rdptr_d     = rdptr_q + AW'(rd_acc);
        out_valid_d = rd_acc;
        out_d       = out_q;
        push        = '0;
        drop        = '0;
        wrptr_d     = wrptr_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < col; i++) begin
            // A full column can still take a push when a pop frees a slot in the same cycle.
            push[i]    = wr[i] && ((cnt_q[i] != FULL_CNT) || rd_acc);
            drop[i]    = wr[i] && !push[i];
            wrptr_d[i] = wrptr_q[i] + AW'(push[i]);
            cnt_d[i]   = cnt_q[i] + CW'(push[i]) - CW'(rd_acc);
            // The read sees pre-edge storage, so a same-cycle push never bypasses to out.
            if (rd_acc)
                out_d[i*psum_bw +: psum_bw] = mem_q[i][rdptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrptr_q     <= '0;
            cnt_q       <= '0;
            rdptr_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wrptr_q     <= wrptr_d;
            cnt_q       <= cnt_d;
            rdptr_q     <= rdptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Writes are gated by reset so a push that coincides with reset has no effect.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (push[i] && reset)
                mem_q[i][wrptr_q[i]] <= in[i*psum_bw +: psum_bw];
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    always_comb overflow_d = overflow_q | (|drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign o_overflow = overflow_q;
`else
    // Without the flag, dropped pushes are silent.
    logic unused_drop;
    assign unused_drop = |drop;
`endif

endmodule

// File: tb/tb_out_fifo_array.sv
module tb_out_fifo_array;

    localparam int PB = 16;
    localparam int C  = 8;
    localparam int D  = 64;

    logic              clk;
    logic              reset;
    logic [PB*C-1:0]   in;
    logic [C-1:0]      wr;
    logic              rd;
    logic              o_valid, o_full, o_ready, out_valid;
    logic [PB*C-1:0]   out;
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
    logic              o_overflow;
`endif

    int checks   = 0;
    int failures = 0;

    out_fifo_array #(.psum_bw(PB), .col(C), .depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .wr        (wr),
        .rd        (rd),
        .o_valid   (o_valid),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .out       (out),
        .out_valid (out_valid)
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row with the same value in every column.
    function automatic logic [PB*C-1:0] row_same(input logic [PB-1:0] v);
        logic [PB*C-1:0] r;
        for (int i = 0; i < C; i++) r[i*PB +: PB] = v;
        return r;
    endfunction

    // Row with column i = base + i.
    function automatic logic [PB*C-1:0] row_inc(input logic [PB-1:0] base);
        logic [PB*C-1:0] r;
        for (int i = 0; i < C; i++) r[i*PB +: PB] = base + PB'(i);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        wr = '0; rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wr    = 8'hFF;
        rd    = 1'b1;
        in    = row_inc(16'h5A00);
        repeat (3) tick;
        checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_o_full got=%b exp=0", o_full); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
`endif
        wr = '0; rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // First push after release lands in entry 0 and is the first row read.
        in = row_inc(16'h0AA0); wr = 8'hFF;
        tick;
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL first_push_valid got=%b exp=1", o_valid); end
        rd = 1'b1;
        tick;
        rd = 1'b0;
        checks++; if (out !== row_inc(16'h0AA0)) begin failures++; $display("FAIL first_push_data got=%h exp=%h", out, row_inc(16'h0AA0)); end
    endtask

    task automatic test_skewed_fill;
        logic exp_v;
        do_reset;
        in = row_inc(16'h0100);
        for (int i = 0; i < C; i++) begin
            wr = C'(1) << i;
            tick;
            exp_v = (i == C - 1);
            checks++; if (o_valid !== exp_v) begin failures++; $display("FAIL skew_o_valid col=%0d got=%b exp=%b", i, o_valid, exp_v); end
        end
        wr = '0; rd = 1'b1;
        tick;
        rd = 1'b0;
        checks++; if (out !== row_inc(16'h0100)) begin failures++; $display("FAIL skew_out got=%h exp=%h", out, row_inc(16'h0100)); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL skew_out_valid got=%b exp=1", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skew_pulse_end got=%b exp=0", out_valid); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL skew_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_fill_overflow;
        do_reset;
        for (int v = 0; v <= D; v++) begin
            in = row_same(PB'(v)); wr = 8'hFF;
            tick;
            if (v == D - 2) begin
                checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL fill_not_full got=%b exp=0", o_full); end
            end
            if (v == D - 1) begin
                checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", o_full); end
                checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", o_ready); end
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
                checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", o_overflow); end
`endif
            end
        end
        wr = '0;
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL drop_full got=%b exp=1", o_full); end
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL drop_ovf got=%b exp=1", o_overflow); end
`endif
        rd = 1'b1;
        for (int k = 0; k < D; k++) begin
            tick;
            checks++; if (out !== row_same(PB'(k))) begin failures++; $display("FAIL drain_row k=%0d got=%h exp=%h", k, out, row_same(PB'(k))); end
        end
        rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_full_push_read;
        do_reset;
        wr = 8'hFF;
        for (int k = 0; k < D; k++) begin
            in = row_same(16'h1000 + PB'(k));
            tick;
        end
        in = row_same(16'hBEEF); wr = 8'hFF; rd = 1'b1;
        tick;
        wr = '0; rd = 1'b0;
        checks++; if (out !== row_same(16'h1000)) begin failures++; $display("FAIL fpr_out got=%h exp=%h", out, row_same(16'h1000)); end
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL fpr_full got=%b exp=1", o_full); end
`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL fpr_ovf got=%b exp=0", o_overflow); end
`endif
        rd = 1'b1;
        for (int k = 1; k <= D; k++) begin
            logic [PB*C-1:0] exp_r;
            exp_r = (k == D) ? row_same(16'hBEEF) : row_same(16'h1000 + PB'(k));
            tick;
            checks++; if (out !== exp_r) begin failures++; $display("FAIL fpr_drain k=%0d got=%h exp=%h", k, out, exp_r); end
        end
        rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL fpr_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_wrap;
        int nin, nout;
        do_reset;
        nin = 0; nout = 0;
        wr = 8'hFF;
        repeat (3) begin
            in = row_inc(PB'(nin * 16)); nin++;
            tick;
        end
        rd = 1'b1;
        repeat (197) begin
            in = row_inc(PB'(nin * 16)); nin++;
            tick;
            checks++; if (out !== row_inc(PB'(nout * 16)) || out_valid !== 1'b1) begin
                failures++; $display("FAIL wrap_row n=%0d got=%h v=%b exp=%h", nout, out, out_valid, row_inc(PB'(nout * 16)));
            end
            nout++;
        end
        wr = '0;
        repeat (3) begin
            tick;
            checks++; if (out !== row_inc(PB'(nout * 16))) begin failures++; $display("FAIL wrap_tail n=%0d got=%h exp=%h", nout, out, row_inc(PB'(nout * 16))); end
            nout++;
        end
        rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_illegal_read_reset;
        do_reset;
        in = row_inc(16'h2000); wr = 8'hFF;
        tick;
        wr = '0; rd = 1'b1;
        tick;
        rd = 1'b0;
        // Column 7 now empty; the read must be ignored.
        in = row_inc(16'h2100); wr = 8'h7F; rd = 1'b1;
        tick;
        wr = '0; rd = 1'b0;
        checks++; if (out !== row_inc(16'h2000)) begin failures++; $display("FAIL illegal_out got=%h exp=%h", out, row_inc(16'h2000)); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_out_valid got=%b exp=0", out_valid); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL illegal_o_valid got=%b exp=0", o_valid); end
        wr = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            in = row_same(16'h2200 + PB'(k));
            tick;
        end
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", o_valid); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", o_valid); end
        checks++; if (out !== '0) begin failures++; $display("FAIL async_reset_out got=%h exp=0", out); end
        @(negedge clk);
        reset = 1'b1;
        in = row_inc(16'h3000); wr = 8'hFF;
        tick;
        wr = '0; rd = 1'b1;
        tick;
        rd = 1'b0;
        checks++; if (out !== row_inc(16'h3000)) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", out, row_inc(16'h3000)); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL post_reset_empty got=%b exp=0", o_valid); end
    endtask

    initial begin
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        test_reset;
        test_skewed_fill;
        test_fill_overflow;
        test_full_push_read;
        test_wrap;
        test_illegal_read_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
